// File: rtl/rtc_edit_ctrl.sv
// Edit-mode sequencer for the RTC time/date field registers: field select, button gating,
// snapshot-load gating and write-back handshake. Optional inactivity abort: RTC_EDIT_TIMEOUT_EN.
module rtc_edit_ctrl #(
    parameter int              TO_W    = 27,
    parameter logic [TO_W-1:0] TIMEOUT = 27'd100_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EDIT_BTN,
    input  logic       NEXT_BTN,
    input  logic       UP_BTN,
    input  logic       DOWN_BTN,
    input  logic       RD_VALID,
    input  logic       WR_ACK,
    output logic [2:0] FIELD,
    output logic [5:0] MOD,
    output logic       UP_OUT,
    output logic       DOWN_OUT,
    output logic       ACT,
    output logic       WR_REQ,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [2:0] LAST_FIELD = 3'd5;

    state_t     state_reg, state_next;
    logic [2:0] field_reg, field_next;
    logic [5:0] mod_reg, mod_next;
    logic       up_reg, up_next;
    logic       down_reg, down_next;
    logic       act_reg, act_next;
    logic       wr_req_reg, wr_req_next;
    logic       busy_reg, busy_next;

`ifdef RTC_EDIT_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - 1'b1;

    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            any_btn;
    logic            to_expired;

    assign any_btn    = EDIT_BTN | NEXT_BTN | UP_BTN | DOWN_BTN;
    assign to_expired = (to_cnt_reg == TO_LAST);

    // Idle cycles spent in EDIT; any button or a fresh entry restarts the count.
    always_comb begin
        to_cnt_next = '0;
        if (state_reg == EDIT && state_next == EDIT && !any_btn)
            to_cnt_next = to_cnt_reg + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            to_cnt_reg <= '0;
        else
            to_cnt_reg <= to_cnt_next;
    end
`else
    localparam logic [TO_W-1:0] unused_timeout = TIMEOUT;
`endif

    always_comb begin
        state_next  = state_reg;
        field_next  = field_reg;
        mod_next    = 6'd0;
        up_next     = 1'b0;
        down_next   = 1'b0;
        act_next    = 1'b0;
        wr_req_next = 1'b0;
        case (state_reg)
            IDLE: begin
                act_next = RD_VALID;
                if (EDIT_BTN) begin
                    state_next = EDIT;
                    field_next = 3'd0;
                    mod_next   = 6'd1;
                end
            end
            EDIT: begin
                mod_next = 6'd1 << field_reg;
                if (EDIT_BTN) begin
                    state_next  = COMMIT;
                    mod_next    = 6'd0;
                    wr_req_next = 1'b1;
                end else if (NEXT_BTN) begin
                    field_next = (field_reg == LAST_FIELD) ? 3'd0 : field_reg + 3'd1;
                    mod_next   = 6'd1 << field_next;
                end else if (UP_BTN || DOWN_BTN) begin
                    // Simultaneous UP and DOWN cancel each other.
                    up_next   = UP_BTN & ~DOWN_BTN;
                    down_next = DOWN_BTN & ~UP_BTN;
                end
`ifdef RTC_EDIT_TIMEOUT_EN
                else if (to_expired) begin
                    state_next = IDLE;
                    mod_next   = 6'd0;
                end
`endif
            end
            COMMIT: begin
                if (WR_ACK)
                    state_next = IDLE;
                else
                    wr_req_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg  <= IDLE;
            field_reg  <= 3'd0;
            mod_reg    <= 6'd0;
            up_reg     <= 1'b0;
            down_reg   <= 1'b0;
            act_reg    <= 1'b0;
            wr_req_reg <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            field_reg  <= field_next;
            mod_reg    <= mod_next;
            up_reg     <= up_next;
            down_reg   <= down_next;
            act_reg    <= act_next;
            wr_req_reg <= wr_req_next;
            busy_reg   <= busy_next;
        end
    end

    assign FIELD    = field_reg;
    assign MOD      = mod_reg;
    assign UP_OUT   = up_reg;
    assign DOWN_OUT = down_reg;
    assign ACT      = act_reg;
    assign WR_REQ   = wr_req_reg;
    assign BUSY     = busy_reg;

endmodule

// File: tb/tb_rtc_edit_ctrl.sv
// Scoreboard bench for rtc_edit_ctrl: stimulus queues the expected post-edge outputs,
// a monitor compares them one cycle at a time.
module tb_rtc_edit_ctrl;

    logic       CLK, RST;
    logic       EDIT_BTN, NEXT_BTN, UP_BTN, DOWN_BTN, RD_VALID, WR_ACK;
    logic [2:0] FIELD;
    logic [5:0] MOD;
    logic       UP_OUT, DOWN_OUT, ACT, WR_REQ, BUSY;

    rtc_edit_ctrl #(.TO_W(27), .TIMEOUT(27'd20)) dut (
        .CLK(CLK), .RST(RST),
        .EDIT_BTN(EDIT_BTN), .NEXT_BTN(NEXT_BTN), .UP_BTN(UP_BTN), .DOWN_BTN(DOWN_BTN),
        .RD_VALID(RD_VALID), .WR_ACK(WR_ACK),
        .FIELD(FIELD), .MOD(MOD), .UP_OUT(UP_OUT), .DOWN_OUT(DOWN_OUT),
        .ACT(ACT), .WR_REQ(WR_REQ), .BUSY(BUSY)
    );

    // input vector {EDIT,NEXT,UP,DOWN,RD_VALID,WR_ACK}
    localparam logic [5:0] I0 = 6'b000000;
    localparam logic [5:0] IE = 6'b100000;
    localparam logic [5:0] IN = 6'b010000;
    localparam logic [5:0] IU = 6'b001000;
    localparam logic [5:0] ID = 6'b000100;
    localparam logic [5:0] IR = 6'b000010;
    localparam logic [5:0] IA = 6'b000001;
    // output flags {UP_OUT,DOWN_OUT,ACT,WR_REQ,BUSY}
    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_ACT  = 5'b00100;
    localparam logic [4:0] O_EDIT = 5'b00001;
    localparam logic [4:0] O_UP   = 5'b10001;
    localparam logic [4:0] O_DN   = 5'b01001;
    localparam logic [4:0] O_WR   = 5'b00011;

    typedef struct {
        string       name;
        logic [13:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [13:0] dut_vec();
        return {FIELD, MOD, UP_OUT, DOWN_OUT, ACT, WR_REQ, BUSY};
    endfunction

    // Monitor: one expected entry per clock edge after which the outputs are checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                total++;
                if (dut_vec() !== e.v) begin
                    bad++;
                    $display("FAIL %s: got %b want %b", e.name, dut_vec(), e.v);
                end else begin
                    $display("ok   %s: %b", e.name, e.v);
                end
            end
        end
    end

    // Apply inputs for one cycle (from negedge to negedge) and queue the outputs expected after the edge.
    task automatic step(input string nm, input logic [5:0] in,
                        input logic [2:0] f, input logic [5:0] m, input logic [4:0] o);
        exp_t e;
        {EDIT_BTN, NEXT_BTN, UP_BTN, DOWN_BTN, RD_VALID, WR_ACK} = in;
        e.name = nm;
        e.v    = {f, m, o};
        sb.push_back(e);
        @(negedge CLK);
        {EDIT_BTN, NEXT_BTN, UP_BTN, DOWN_BTN, RD_VALID, WR_ACK} = I0;
    endtask

    task automatic direct_check(input string nm, input logic [13:0] want);
        total++;
        if (dut_vec() !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, dut_vec(), want);
        end else begin
            $display("ok   %s: %b", nm, want);
        end
    endtask

    initial begin
        int wait_cyc;
        RST = 1'b1;
        {EDIT_BTN, NEXT_BTN, UP_BTN, DOWN_BTN, RD_VALID, WR_ACK} = I0;
        RD_VALID = 1'b1;
        repeat (3) @(negedge CLK);
        direct_check("reset_state", 14'd0);
        RD_VALID = 1'b0;
        RST      = 1'b0;

        step("idle_rd_act",    IR, 3'd0, 6'b000000, O_ACT);
        step("idle_act_1cyc",  I0, 3'd0, 6'b000000, O_IDLE);
        step("enter_edit",     IE, 3'd0, 6'b000001, O_EDIT);
        step("next_1",         IN, 3'd1, 6'b000010, O_EDIT);
        step("next_2",         IN, 3'd2, 6'b000100, O_EDIT);
        step("next_3",         IN, 3'd3, 6'b001000, O_EDIT);
        step("next_4",         IN, 3'd4, 6'b010000, O_EDIT);
        step("next_5",         IN, 3'd5, 6'b100000, O_EDIT);
        step("next_wrap",      IN, 3'd0, 6'b000001, O_EDIT);
        step("up_pulse",       IU, 3'd0, 6'b000001, O_UP);
        step("up_1cyc",        I0, 3'd0, 6'b000001, O_EDIT);
        step("up_down_cancel", IU | ID, 3'd0, 6'b000001, O_EDIT);
        step("down_pulse",     ID, 3'd0, 6'b000001, O_DN);
        step("rd_in_edit",     IR, 3'd0, 6'b000001, O_EDIT);
        step("next_to_1",      IN, 3'd1, 6'b000010, O_EDIT);
        step("up_new_field",   IU, 3'd1, 6'b000010, O_UP);
        step("next_over_up",   IN | IU, 3'd2, 6'b000100, O_EDIT);
        step("ack_in_edit",    IA, 3'd2, 6'b000100, O_EDIT);
        step("commit",         IE | IN | IU, 3'd2, 6'b000000, O_WR);
        for (int i = 0; i < 10; i++) begin
            logic [5:0] noise;
            case (i % 5)
                0: noise = IE;
                1: noise = IN;
                2: noise = IU;
                3: noise = IR;
                default: noise = I0;
            endcase
            step($sformatf("commit_hold_%0d", i), noise, 3'd2, 6'b000000, O_WR);
        end
        step("ack_release",    IA, 3'd2, 6'b000000, O_IDLE);
        step("idle_reload",    IR, 3'd2, 6'b000000, O_ACT);
        step("edit_again",     IE, 3'd0, 6'b000001, O_EDIT);
        step("commit_again",   IE, 3'd0, 6'b000000, O_WR);
        step("ack_first_cyc",  IA, 3'd0, 6'b000000, O_IDLE);
        step("ack_idle_ign",   IA, 3'd0, 6'b000000, O_IDLE);

        // Reset in COMMIT must withdraw WR_REQ without a clock edge.
        step("edit_pre_rst",   IE, 3'd0, 6'b000001, O_EDIT);
        step("commit_pre_rst", IE, 3'd0, 6'b000000, O_WR);
        #2;
        RST = 1'b1;
        #1;
        direct_check("async_rst_commit", 14'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        step("post_rst_idle",  I0, 3'd0, 6'b000000, O_IDLE);

`ifdef RTC_EDIT_TIMEOUT_EN
        step("to_enter",       IE, 3'd0, 6'b000001, O_EDIT);
        for (int k = 1; k < 20; k++)
            step($sformatf("to_wait_%0d", k), I0, 3'd0, 6'b000001, O_EDIT);
        step("to_abort_20",    I0, 3'd0, 6'b000000, O_IDLE);
        step("to_rd_restore",  IR, 3'd0, 6'b000000, O_ACT);
        step("to2_enter",      IE, 3'd0, 6'b000001, O_EDIT);
        for (int k = 1; k < 15; k++)
            step($sformatf("to2_wait_%0d", k), I0, 3'd0, 6'b000001, O_EDIT);
        step("to2_next_15",    IN, 3'd1, 6'b000010, O_EDIT);
        for (int k = 16; k < 35; k++)
            step($sformatf("to2_wait_%0d", k), I0, 3'd1, 6'b000010, O_EDIT);
        step("to2_abort_35",   I0, 3'd1, 6'b000000, O_IDLE);
`else
        step("persist_enter",  IE, 3'd0, 6'b000001, O_EDIT);
        for (int k = 1; k <= 40; k++)
            step($sformatf("persist_%0d", k), I0, 3'd0, 6'b000001, O_EDIT);
        step("persist_commit", IE, 3'd0, 6'b000000, O_WR);
        step("persist_ack",    IA, 3'd0, 6'b000000, O_IDLE);
`endif

        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 10) begin
            @(negedge CLK);
            wait_cyc++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
